arbitro_display: RTL
====================

ARBITRO_DISPLAY -- requirements
Module: arbitro_display

Interface
REQ-001 The block SHALL have parameter P_HOLD_CYCLES, default 50000, meaning the minimum number of i_Clk cycles a granted value stays on the display before another grant; legal range 1..2^20-1.
REQ-002 The block SHALL have port i_Clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_Rst  input  1  synchronous, active-low reset.
REQ-004 The block SHALL have port i_Req0_Valid  input  1  requester 0 has a 4-digit value to show.
REQ-005 The block SHALL have port i_Req0_Datos  input  16  requester 0 value, digit k = bits [4k+3:4k], k=0..3.
REQ-006 The block SHALL have port o_Req0_Ready  output  1  requester 0 value accepted this cycle.
REQ-007 The block SHALL have ports i_Req1_Valid (input, 1), i_Req1_Datos (input, 16) and o_Req1_Ready (output, 1), identical in meaning for requester 1.
REQ-008 The block SHALL have ports o_Datos1, o_Datos2, o_Datos3, o_Datos4  output  4 each  displayed digits, o_Datos1 = bits [3:0] … o_Datos4 = bits [15:12] of the accepted value, wired to the 4-digit display controller data inputs.
REQ-009 The block SHALL have port o_Owner  output  1  index of the requester whose value is displayed.
REQ-010 The block SHALL have port o_Busy  output  1  high while in GRANT or HOLD.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, GRANT, HOLD.
REQ-012 In IDLE, if either valid is high, the block SHALL select a winner and move to GRANT next cycle; otherwise it SHALL stay in IDLE.
REQ-013 Arbitration SHALL be round-robin: on simultaneous valids, the requester that did not win the last completed transfer wins; after reset, requester 0 has priority.
REQ-014 With a single valid requester, that requester SHALL win regardless of the round-robin pointer.
REQ-015 o_ReqX_Ready SHALL be registered, high only during the single GRANT cycle, and only for the winner.
REQ-016 A transfer SHALL occur when the winner’s valid and ready are both high; the display outputs and o_Owner SHALL update on the next edge, giving 2-cycle latency from valid sampled in IDLE to new o_DatosN.
REQ-017 On a transfer, the block SHALL load the hold counter with P_HOLD_CYCLES-1, move to HOLD, and advance the round-robin pointer away from the winner.
REQ-018 If the winner’s valid is low in GRANT, the block SHALL perform no transfer, leave outputs, o_Owner and pointer unchanged, and return to IDLE.
REQ-019 In HOLD, the counter SHALL decrement by one per cycle; when it is 0, the next state SHALL be IDLE, giving exactly P_HOLD_CYCLES cycles in HOLD.
REQ-020 Valids arriving during GRANT or HOLD SHALL be ignored until IDLE; requesters hold valid and data stable until ready.
REQ-021 The loser’s ready SHALL stay low; its request is served at the next IDLE if still valid.
REQ-022 The hold counter SHALL be 20 bits wide, never wrap below 0, and be unaffected by data values.

Reset
REQ-023 While i_Rst is low at a rising edge, the block SHALL next-cycle force state IDLE, counter 0, pointer to requester 0, o_Datos1..4 = 4'h0, o_Owner = 0, both readies 0, and o_Busy = 0.
REQ-024 Reset asserted in GRANT or HOLD SHALL abort the cycle with no transfer; reset SHALL take priority over all other events in the same cycle.

Verification
REQ-025 Reset, then i_Req0_Valid=1 with Datos=16'h1234, held until ready, SHALL give o_Req0_Ready high one cycle 1 cycle later, and 2 cycles after valid was sampled: o_Datos4..1 = 1,2,3,4, o_Owner=0.
REQ-026 With P_HOLD_CYCLES=4, both valids high continuously with Req0=16'hAAAA and Req1=16'h5555, grants SHALL alternate 0,1,0,…, with each grant 6 cycles apart (GRANT, 4 HOLD, IDLE).
REQ-027 Req1 valid for only 1 cycle in IDLE, dropping before GRANT, SHALL give no transfer, unchanged outputs, and a return to IDLE.
REQ-028 i_Rst low during HOLD SHALL give all outputs 0 and o_Busy=0 next cycle; a pending Req1 SHALL then be granted from IDLE.
REQ-029 With P_HOLD_CYCLES=1, back-to-back Req0 values SHALL be accepted every 3 cycles, each visible for at least 1 HOLD cycle.

Source files
------------

// File: rtl/arbitro_display.sv
// Round-robin arbiter between two requesters sharing a 4-digit display.
// The accepted value stays on the display for at least P_HOLD_CYCLES cycles.
module arbitro_display #(
  parameter int P_HOLD_CYCLES = 50000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Req0_Valid,
  input  logic [15:0] i_Req0_Datos,
  output logic        o_Req0_Ready,
  input  logic        i_Req1_Valid,
  input  logic [15:0] i_Req1_Datos,
  output logic        o_Req1_Ready,
  output logic [3:0]  o_Datos1,
  output logic [3:0]  o_Datos2,
  output logic [3:0]  o_Datos3,
  output logic [3:0]  o_Datos4,
  output logic        o_Owner,
  output logic        o_Busy
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_GRANT   = 2'd1;
  localparam logic [1:0]  S_HOLD    = 2'd2;
  localparam logic [19:0] HOLD_LOAD = 20'(P_HOLD_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        ptr_q, ptr_d;
  logic        win_q, win_d;
  logic [1:0]  rdy_q, rdy_d;
  logic [15:0] disp_q, disp_d;
  logic        owner_q, owner_d;

  logic [1:0]  valid_vec;
  logic        pick;
  logic        win_valid;
  logic [15:0] win_data;

  assign valid_vec = {i_Req1_Valid, i_Req0_Valid};

  // ptr_q names the requester that wins a tie; a lone requester always wins.
  assign pick      = (valid_vec == 2'b11) ? ptr_q : valid_vec[1];
  assign win_valid = win_q ? i_Req1_Valid : i_Req0_Valid;
  assign win_data  = win_q ? i_Req1_Datos : i_Req0_Datos;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    rdy_d   = 2'b00;
    disp_d  = disp_q;
    owner_d = owner_q;
    case (state_q)
      S_IDLE: begin
        if (|valid_vec) begin
          win_d   = pick;
          rdy_d   = pick ? 2'b10 : 2'b01;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (win_valid) begin
          disp_d  = win_data;
          owner_d = win_q;
          cnt_d   = HOLD_LOAD;
          ptr_d   = ~win_q;
          state_d = S_HOLD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cnt_q == 20'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 20'd0;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      rdy_q   <= 2'b00;
      disp_q  <= 16'h0000;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      rdy_q   <= rdy_d;
      disp_q  <= disp_d;
      owner_q <= owner_d;
    end
  end

  assign o_Req0_Ready = rdy_q[0];
  assign o_Req1_Ready = rdy_q[1];
  assign o_Datos1     = disp_q[3:0];
  assign o_Datos2     = disp_q[7:4];
  assign o_Datos3     = disp_q[11:8];
  assign o_Datos4     = disp_q[15:12];
  assign o_Owner      = owner_q;
  assign o_Busy       = (state_q == S_GRANT) || (state_q == S_HOLD);

endmodule
